// File: rtl/demux16_deserializer.sv
// demux16_deserializer: rebuilds a parallel word from a serial bit stream
// produced by a mux-driven link. Bits are written LSB first at index sel.
// The finished word is presented with a valid/ready handshake.
//
// Ports:
//   clk        system clock, rising edge
//   rst        asynchronous active-high reset
//   start      begin a new word (also aborts a partial word)
//   din        serial data bit
//   din_valid  din is valid this cycle
//   out_ready  downstream accepts the word
//   dout       assembled word (registered)
//   out_valid  dout holds a complete word (registered)
//   sel        index the next valid bit will be written to (registered)
//   busy       high while collecting bits (registered)
//   overrun    sticky: data arrived while a word was waiting (registered)
module demux16_deserializer #(
    parameter int unsigned N    = 16,
    parameter int unsigned SELW = 4
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic            din,
    input  logic            din_valid,
    input  logic            out_ready,
    output logic [N-1:0]    dout,
    output logic            out_valid,
    output logic [SELW-1:0] sel,
    output logic            busy,
    output logic            overrun
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        COLLECT = 2'd1,
        HOLD    = 2'd2
    } state_t;

    localparam logic [SELW-1:0] LAST_SEL = SELW'(N - 1);

    state_t          state, state_n;
    logic [N-1:0]    shadow, shadow_n;
    logic [N-1:0]    dout_n;
    logic            out_valid_n;
    logic [SELW-1:0] sel_n;
    logic            busy_n;
    logic            overrun_n;

    // State and datapath registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            shadow    <= '0;
            dout      <= '0;
            out_valid <= 1'b0;
            sel       <= '0;
            busy      <= 1'b0;
            overrun   <= 1'b0;
        end else begin
            state     <= state_n;
            shadow    <= shadow_n;
            dout      <= dout_n;
            out_valid <= out_valid_n;
            sel       <= sel_n;
            busy      <= busy_n;
            overrun   <= overrun_n;
        end
    end

    // Next-state and next-output logic
    always_comb begin
        state_n     = state;
        shadow_n    = shadow;
        dout_n      = dout;
        out_valid_n = out_valid;
        sel_n       = sel;
        overrun_n   = overrun;

        unique case (state)
            IDLE: begin
                if (start) begin
                    state_n  = COLLECT;
                    sel_n    = '0;
                    shadow_n = '0;
                end
            end

            COLLECT: begin
                // start wins over a coincident valid bit; that bit is dropped
                if (start) begin
                    sel_n    = '0;
                    shadow_n = '0;
                end else if (din_valid) begin
                    shadow_n[sel] = din;
                    sel_n         = SELW'(sel + SELW'(1));
                    // Final bit loads dout directly, including the incoming bit
                    if (sel == LAST_SEL) begin
                        dout_n      = shadow_n;
                        out_valid_n = 1'b1;
                        state_n     = HOLD;
                    end
                end
            end

            HOLD: begin
                if (out_valid && out_ready) begin
                    out_valid_n = 1'b0;
                    if (start) begin
                        state_n  = COLLECT;
                        sel_n    = '0;
                        shadow_n = '0;
                    end else begin
                        state_n = IDLE;
                    end
                end else if (din_valid) begin
                    overrun_n = 1'b1;
                end
            end

            default: begin
                state_n = IDLE;
            end
        endcase

        busy_n = (state_n == COLLECT);
    end

endmodule

// File: doc/demux16_deserializer.md
Name: demux16_deserializer

Overview:
- Receive-side counterpart of the 16-to-1 mux path.
- Takes a serial bit stream and writes each bit into word position sel, where sel counts 0..15, LSB first. This mirrors mux16to1 selecting in[sel] onto out.
- Presents the assembled 16-bit word with a valid/ready handshake.
- Sits after a mux-driven serial link and rebuilds the parallel word for downstream logic.

Parameters:
- N, 16, word width in bits; must be a power of two.
- SELW, 4, select/index width; must equal log2(N).

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst  input  1  asynchronous, active-high reset.
- start  input  1  pulse that begins a new word; resets the index to 0.
- din  input  1  serial data bit.
- din_valid  input  1  din is valid this cycle.
- out_ready  input  1  downstream accepts the word.
- dout  output  N  assembled word.
- out_valid  output  1  dout holds a complete word.
- sel  output  SELW  index the next valid bit will be written to.
- busy  output  1  high in COLLECT.
- overrun  output  1  sticky error flag.

Behaviour:
- Reset (asynchronous, rst=1):
  - State goes to IDLE.
  - dout=0, out_valid=0, sel=0, busy=0, overrun=0.
  - The internal shadow register clears to 0.
- States: IDLE, COLLECT, HOLD.
- IDLE:
  - din_valid is ignored.
  - start=1 -> COLLECT, sel=0, shadow cleared.
- COLLECT (busy=1):
  - Each cycle with din_valid=1: shadow[sel] <= din, then sel <= sel+1.
  - din_valid=0: no change.
  - On the edge that captures the bit at sel=N-1:
    - dout <= shadow with bit N-1 = din. This is a single-edge load with no extra cycle.
    - out_valid <= 1, sel wraps to 0, state -> HOLD.
  - Latency: out_valid rises on the same edge that captures the Nth valid bit.
  - start=1 in COLLECT aborts the word: sel=0, shadow cleared, state stays COLLECT, partial data discarded. start has priority over din_valid in that cycle, so the bit is dropped.
- HOLD:
  - out_valid=1; dout is stable until the handshake.
  - The handshake completes on an edge with out_valid=1 and out_ready=1: out_valid <= 0.
    - If start=1 on the same edge: -> COLLECT, sel=0.
    - Otherwise -> IDLE.
  - din_valid=1 while in HOLD (on any edge where the handshake does not complete) sets overrun=1; the bit is dropped.
  - overrun clears only on rst.
  - start without the handshake in HOLD is ignored.
- out_ready has no effect outside HOLD.
- sel arithmetic is modulo N; no other width extension.
- Reset mid-word: everything returns to reset values immediately (asynchronous), and the partial word is lost.

Test Plan:
- Reset, then start, then 16 valid bits of 16'h3f0a LSB first (0,1,0,1,0,0,0,0,1,1,1,1,1,1,0,0), out_ready=0.
  - Required: out_valid=1 on the 16th bit's edge, dout=16'h3f0a, sel=0, busy=0.
  - Then out_ready=1 for one cycle -> out_valid=0, state IDLE.
- Same word as above, with din_valid deasserted for 3 random gaps.
  - Required: dout=16'h3f0a; out_valid is asserted only after exactly 16 valid cycles.
  - sel increments only on valid cycles and reads 5 after the 5th valid bit.
- start, then 7 bits of 1, then start again, then 16 bits of 16'hA5C3 LSB first.
  - Required: dout=16'hA5C3, with no contamination from the aborted word.
- Word 16'h0001 held with out_ready=0, then din_valid=1 for 2 cycles.
  - Required: overrun=1 and stays 1; dout stays 16'h0001.
  - After the handshake: overrun is still 1.
  - Only rst clears it.
- In HOLD, out_ready=1 and start=1 on the same edge, then 16 bits of 16'hFFFF.
  - Required: no IDLE cycle (busy=1 the next cycle), second dout=16'hFFFF.
- rst pulse asserted asynchronously after 9 bits, between clock edges.
  - Required: immediately out_valid=0, sel=0, dout=0, busy=0.
  - Then start plus a full 16'h3f0a word is received correctly.
